ram_sp_sync_be: RTL

- Parametrised successor to the team's single-port synchronous RAM, with separate write and read data buses instead of a tri-state bus.
- Adds per-byte write enables, a configurable read latency with a read-valid strobe, and a parametrised protected upper address region.
- Adds an error strobe and a post-reset clear sweep.
- Sits behind a bus master as local scratch or table storage; one access per clock.

---
 rtl/ram_pkg.sv | 27 ++
 rtl/ram_init_ctrl.sv | 68 ++++++
 rtl/ram_sp_sync_be.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ram_pkg -- shared definitions for the byte-enable single-port RAM.
//
// Contents:
//   ram_state_e        clear-sweep FSM states (ST_INIT, ST_IDLE)
//   RAM_*_DEF          default word width, address width and protected base
//   ram_lanes()        number of byte lanes in a word (DATA_WIDTH/8)
//   ram_rd_latency_ok  legality check for the read latency (1 or 2)
package ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } ram_state_e;

  localparam int RAM_DATA_WIDTH_DEF = 64;
  localparam int RAM_ADDR_WIDTH_DEF = 8;
  localparam int RAM_PROT_BASE_DEF  = 240;

  function automatic int ram_lanes(input int data_width);
    return data_width / 8;
  endfunction

  function automatic bit ram_rd_latency_ok(input int rd_latency);
    return (rd_latency == 1) || (rd_latency == 2);
  endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// ram_init_ctrl -- post-reset clear sweep for ram_sp_sync_be.
//
// After reset it walks every word address once, requesting an all-zero
// write per cycle, then parks in ST_IDLE. busy is high for the whole walk
// (including while rst_n is low), so it drops the cycle after the write
// to the last word.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset; restarts the walk at 0
//   o_busy       high while the sweep owns the memory
//   o_init_we    write strobe for the sweep write port
//   o_init_addr  word address for the sweep write port
module ram_init_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  o_busy,
  output logic                  o_init_we,
  output logic [ADDR_WIDTH-1:0] o_init_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  ram_state_e            r_state;
  ram_state_e            w_state_next;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] w_count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      ST_INIT: begin
        w_count_next = r_count + ADDR_WIDTH'(1);
        if (r_count == LAST_ADDR) begin
          w_state_next = ST_IDLE;
          w_count_next = '0;
        end
      end
      ST_IDLE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_busy      = (r_state == ST_INIT);
  assign o_init_we   = (r_state == ST_INIT);
  assign o_init_addr = r_count;

endmodule

// File: rtl/ram_sp_sync_be.sv
// ram_sp_sync_be -- single-port synchronous RAM with byte-lane write
// enables, 1- or 2-cycle read latency, a protected upper address region
// and an error strobe.
//
// Build option: RAM_INIT_SWEEP_EN
//   defined   -> memory is cleared by ram_init_ctrl after every reset;
//                busy is high and accesses are rejected meanwhile.
//   undefined -> no sweep, busy is tied low, contents undefined until
//                written, first access accepted right after reset.
//
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   cs, we, oe  chip select, 1=write/0=read, read enable
//   address     word address
//   wdata, be   write data and per-byte write enables
//   rdata       read data, holds its value between reads
//   rvalid      one-cycle strobe, rdata valid
//   busy        clear sweep in progress
//   err         one-cycle strobe for a rejected access
module ram_sp_sync_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH_DEF,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int PROT_BASE  = RAM_PROT_BASE_DEF,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cs,
  input  logic                    we,
  input  logic                    oe,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    busy,
  output logic                    err
);

  localparam int LANES = ram_lanes(DATA_WIDTH);
  // Anything other than a legal 2 runs the single-stage read path.
  localparam bit RD_LAT2 = ram_rd_latency_ok(RD_LATENCY) && (RD_LATENCY == 2);
  // One extra bit so a base equal to the depth (no protected region) fits.
  localparam logic [ADDR_WIDTH:0] PROT_LIMIT =
    (PROT_BASE >= RAM_DEPTH) ? (ADDR_WIDTH+1)'(RAM_DEPTH) : (ADDR_WIDTH+1)'(PROT_BASE);

  logic                  w_busy;
  logic                  w_init_we;
  logic [ADDR_WIDTH-1:0] w_init_addr;

`ifdef RAM_INIT_SWEEP_EN
  ram_init_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH)
  ) u_init_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .o_busy      (w_busy),
    .o_init_we   (w_init_we),
    .o_init_addr (w_init_addr)
  );
`else
  assign w_busy      = 1'b0;
  assign w_init_we   = 1'b0;
  assign w_init_addr = '0;
`endif

  // Access decode
  logic w_prot;
  logic w_wr_req;
  logic w_rd_req;
  logic w_access;
  logic w_busy_rej;
  logic w_prot_rej;
  logic w_rd_acc;
  logic w_rd_mem;
  logic w_wr_mem;

  assign w_prot     = ({1'b0, address} >= PROT_LIMIT);
  assign w_wr_req   = cs & we;
  assign w_rd_req   = cs & ~we & oe;
  assign w_access   = w_wr_req | w_rd_req;
  assign w_busy_rej = w_access & w_busy;
  assign w_prot_rej = w_access & ~w_busy & w_prot;
  // A protected read still returns a (zero) word, so it counts as accepted.
  assign w_rd_acc   = w_rd_req & ~w_busy;
  assign w_rd_mem   = w_rd_acc & ~w_prot;
  assign w_wr_mem   = w_wr_req & ~w_busy & ~w_prot;

  // Memory write port: the sweep owns it while busy.
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [LANES-1:0]      w_lane_we;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [DATA_WIDTH-1:0] w_mem_q;

  assign w_mem_addr  = w_init_we ? w_init_addr : address;
  assign w_lane_we   = w_init_we ? {LANES{1'b1}} : (w_wr_mem ? be : '0);
  assign w_mem_wdata = w_init_we ? '0 : wdata;

  // One byte-wide array per lane keeps the byte enables a plain write
  // enable on each RAM slice.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] r_mem [RAM_DEPTH];
    logic [7:0] r_lane_q;

    always_ff @(posedge clk) begin
      if (w_lane_we[gi]) begin
        r_mem[w_mem_addr] <= w_mem_wdata[8*gi +: 8];
      end
      if (w_rd_mem) begin
        r_lane_q <= r_mem[address];
      end
    end

    assign w_mem_q[8*gi +: 8] = r_lane_q;
  end

  // First output stage. r_zero1 masks the RAM output register, which has
  // no reset, so rdata reads 0 after reset and after a protected read.
  logic r_rvalid1;
  logic r_zero1;
  logic r_prot_err1;
  logic r_busy_err1;
  logic [DATA_WIDTH-1:0] w_rdata1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid1   <= 1'b0;
      r_zero1     <= 1'b1;
      r_prot_err1 <= 1'b0;
      r_busy_err1 <= 1'b0;
    end else begin
      r_rvalid1   <= w_rd_acc;
      if (w_rd_acc) begin
        r_zero1 <= w_prot;
      end
      r_prot_err1 <= w_prot_rej;
      r_busy_err1 <= w_busy_rej;
    end
  end

  assign w_rdata1 = r_zero1 ? '0 : w_mem_q;

  // Busy rejections always flag after one cycle; protection rejections
  // follow the read latency so they line up with the would-be rvalid.
  if (RD_LAT2) begin : g_lat2
    logic                  r_rvalid2;
    logic                  r_prot_err2;
    logic [DATA_WIDTH-1:0] r_rdata2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rvalid2   <= 1'b0;
        r_prot_err2 <= 1'b0;
        r_rdata2    <= '0;
      end else begin
        r_rvalid2   <= r_rvalid1;
        r_prot_err2 <= r_prot_err1;
        if (r_rvalid1) begin
          r_rdata2 <= w_rdata1;
        end
      end
    end

    assign rvalid = r_rvalid2;
    assign rdata  = r_rdata2;
    assign err    = r_prot_err2 | r_busy_err1;
  end else begin : g_lat1
    assign rvalid = r_rvalid1;
    assign rdata  = w_rdata1;
    assign err    = r_prot_err1 | r_busy_err1;
  end

  assign busy = w_busy;

endmodule
